// File: rtl/mac_ctrl_pkg.sv
// Shared sizing constants and FSM state type for the dot-product MAC controller.
package mac_ctrl_pkg;

    localparam int unsigned pr      = 8;
    localparam int unsigned bw      = 8;
    localparam int unsigned bw_psum = 2 * bw + 3;
    localparam int unsigned max_len = 16;
    localparam int unsigned acc_bw  = bw_psum + 4;
    localparam int unsigned cnt_bw  = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/mac_ctrl_mac.sv
// Two-stage signed dot-product unit: lane products registered, then their sum registered.
module mac #(
    parameter int unsigned pr = 8,
    parameter int unsigned bw = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [pr*bw-1:0]      a,
    input  logic [pr*bw-1:0]      b,
    output logic signed [2*bw+2:0] out
);

    localparam int unsigned PsumW = 2 * bw + 3;

    logic signed [2*bw-1:0]  prod_d [pr];
    logic signed [2*bw-1:0]  prod_q [pr];
    logic signed [PsumW-1:0] sum_d;
    logic signed [PsumW-1:0] out_q;

    always_comb begin
        for (int i = 0; i < pr; i++) begin
            // Sign-extend each lane to full product width before multiplying.
            prod_d[i] = signed'({{bw{a[(i+1)*bw-1]}}, a[i*bw +: bw]}) *
                        signed'({{bw{b[(i+1)*bw-1]}}, b[i*bw +: bw]});
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < pr; i++) begin
            sum_d = sum_d + {{(PsumW-2*bw){prod_q[i][2*bw-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < pr; i++) begin
                prod_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            for (int i = 0; i < pr; i++) begin
                prod_q[i] <= prod_d[i];
            end
            out_q <= sum_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/mac_ctrl.sv
// Job controller: streams up to max_len operand beats through the mac and accumulates the result.
module mac_ctrl
    import mac_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [cnt_bw-1:0]   len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [pr*bw-1:0]    in_a,
    input  logic [pr*bw-1:0]    in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [acc_bw-1:0]   out_data
);

    state_e                    state_q;
    logic [cnt_bw-1:0]         len_q;
    logic [cnt_bw-1:0]         issue_cnt_q;
    logic [cnt_bw-1:0]         rcv_cnt_q;
    logic                      vp0_q;
    logic                      vp1_q;
    logic signed [acc_bw-1:0]  acc_q;
    logic                      busy_q;
    logic                      in_ready_q;
    logic                      out_valid_q;

    logic                      fire;
    logic [pr*bw-1:0]          mac_a;
    logic [pr*bw-1:0]          mac_b;
    logic signed [bw_psum-1:0] mac_out;
    logic signed [acc_bw-1:0]  mac_ext;
    logic [cnt_bw-1:0]         len_c;
    logic                      last_issue;
    logic                      last_rcv;

    assign fire       = in_valid & in_ready_q;
    assign mac_a      = fire ? in_a : '0;
    assign mac_b      = fire ? in_b : '0;
    assign mac_ext    = {{(acc_bw-bw_psum){mac_out[bw_psum-1]}}, mac_out};
    assign len_c      = (len > cnt_bw'(max_len)) ? cnt_bw'(max_len) : len;
    assign last_issue = fire && ((issue_cnt_q + cnt_bw'(1)) == len_q);
    assign last_rcv   = vp1_q && ((rcv_cnt_q + cnt_bw'(1)) == len_q);

    mac #(
        .pr (pr),
        .bw (bw)
    ) u_mac (
        .clk   (clk),
        .reset (~reset_n),
        .a     (mac_a),
        .b     (mac_b),
        .out   (mac_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            len_q       <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            vp0_q       <= 1'b0;
            vp1_q       <= 1'b0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            vp0_q <= fire;
            vp1_q <= vp0_q;
            if (vp1_q) begin
                acc_q     <= acc_q + mac_ext;
                rcv_cnt_q <= rcv_cnt_q + cnt_bw'(1);
            end
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        if (len_c == '0) begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= StRun;
                            len_q       <= len_c;
                            issue_cnt_q <= '0;
                            rcv_cnt_q   <= '0;
                            in_ready_q  <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (fire) begin
                        issue_cnt_q <= issue_cnt_q + cnt_bw'(1);
                    end
                    if (last_issue) begin
                        state_q    <= StDrain;
                        in_ready_q <= 1'b0;
                    end
                    // Results can only complete after the final issue, so this never races it.
                    if (last_rcv) begin
                        state_q     <= StDone;
                        in_ready_q  <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
                end
                StDrain: begin
                    if (last_rcv) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;

endmodule

// File: tb/tb_mac_ctrl.sv
// Directed vector bench for mac_ctrl: job results, latency, reset and DONE-hold behaviour.
module tb_mac_ctrl;
    import mac_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [cnt_bw-1:0] len;
    logic              busy;
    logic              in_valid;
    logic              in_ready;
    logic [pr*bw-1:0]  in_a;
    logic [pr*bw-1:0]  in_b;
    logic              out_valid;
    logic              out_ready;
    logic [acc_bw-1:0] out_data;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int L;
        int a;
        int b;
        bit toggle;
        int exp_data;
        int exp_cyc;
    } vec_t;

    vec_t vecs[7];

    mac_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    function automatic logic [pr*bw-1:0] splat(input int v);
        logic [pr*bw-1:0] r;
        for (int i = 0; i < pr; i++) r[i*bw +: bw] = bw'(v);
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycle 0 is the cycle start is high; latency is the first cycle out_valid is seen.
    task automatic run_job(input int L, input int a, input int b, input bit toggle,
                           input int exp_data, input int exp_cyc, input bit do_release,
                           input string tag);
        int sent = 0;
        int cyc  = -1;
        int lc   = (L > 16) ? 16 : L;
        @(posedge clk);
        #1;
        start    = 1'b1;
        len      = cnt_bw'(L);
        in_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (out_valid) begin
                cyc = c;
                break;
            end
            in_valid = (sent < lc) && (!toggle || (c % 2 == 1));
            in_a     = splat(a);
            in_b     = splat(b);
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({tag, " latency"}, cyc, exp_cyc);
        check({tag, " out_data"}, int'($signed(out_data)), exp_data);
        check({tag, " beats accepted"}, sent, lc);
        check({tag, " in_ready in DONE"}, int'(in_ready), 0);
        check({tag, " busy in DONE"}, int'(busy), 1);
        if (do_release) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check({tag, " busy after release"}, int'(busy), 0);
            check({tag, " out_valid after release"}, int'(out_valid), 0);
        end
    endtask

    initial begin
        vecs[0] = '{L: 1,  a: 1,    b: 1,    toggle: 0, exp_data: 8,       exp_cyc: 4};
        vecs[1] = '{L: 16, a: -128, b: -128, toggle: 0, exp_data: 2097152, exp_cyc: 19};
        vecs[2] = '{L: 4,  a: 3,    b: -2,   toggle: 1, exp_data: -192,    exp_cyc: 10};
        vecs[3] = '{L: 0,  a: 0,    b: 0,    toggle: 0, exp_data: 0,       exp_cyc: 1};
        vecs[4] = '{L: 20, a: 2,    b: 3,    toggle: 0, exp_data: 768,     exp_cyc: 19};
        vecs[5] = '{L: 3,  a: -1,   b: 127,  toggle: 0, exp_data: -3048,   exp_cyc: 6};
        vecs[6] = '{L: 2,  a: 127,  b: -128, toggle: 0, exp_data: -260096, exp_cyc: 5};

        reset_n   = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset in_ready", int'(in_ready), 0);
        check("reset out_valid", int'(out_valid), 0);
        check("reset out_data", int'(out_data), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i].L, vecs[i].a, vecs[i].b, vecs[i].toggle,
                    vecs[i].exp_data, vecs[i].exp_cyc, 1'b1, $sformatf("vec%0d", i));
        end

        // Abort a job after two beats; nothing may leak into the next job.
        @(posedge clk);
        #1;
        start = 1'b1;
        len   = 5'd4;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_a     = splat(5);
        in_b     = splat(5);
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("midjob reset busy", int'(busy), 0);
        check("midjob reset in_ready", int'(in_ready), 0);
        check("midjob reset out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_job(2, 1, 2, 1'b0, 32, 5, 1'b1, "post-reset");

        // Hold in DONE with out_ready low and a stray start.
        run_job(1, 1, 1, 1'b0, 8, 4, 1'b0, "hold");
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            len   = 5'd3;
            @(posedge clk);
            #1;
            check($sformatf("hold%0d out_valid", k), int'(out_valid), 1);
            check($sformatf("hold%0d out_data", k), int'($signed(out_data)), 8);
            check($sformatf("hold%0d in_ready", k), int'(in_ready), 0);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hold release busy", int'(busy), 0);
        check("hold release out_valid", int'(out_valid), 0);
        @(posedge clk);
        #1;
        check("hold start ignored", int'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
